// File: rtl/led_pattern_sched.sv
// Step/mode sequencer for the 8-LED pattern engine: prescaled step enable, hold and mode rotation.
// Optional: define SCHED_DWELL_EN to hold in SWITCH for DWELL_TICKS prescaler periods after auto mode changes.
//
// state | meaning
// 00    | IDLE   : engine held, waiting for run_req
// 01    | RUN    : prescaler counting, engine stepping
// 10    | PAUSE  : engine held, prescaler phase kept
// 11    | SWITCH : load next mode, clear counters, flush engine

module led_pattern_sched #(
  parameter int DIV_W          = 24,
  parameter int DIV_CYCLES     = 12500000,
  parameter int STEP_W         = 8,
  parameter int STEPS_PER_MODE = 32
`ifdef SCHED_DWELL_EN
  ,
  parameter int DWELL_TICKS    = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              next_req,
  input  logic              auto_en,
  input  logic [1:0]        man_mode,
  output logic              eng_tick,
  output logic              eng_ss,
  output logic [1:0]        eng_mode,
  output logic [STEP_W-1:0] step_cnt,
  output logic [1:0]        state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSE  = 2'b10;
  localparam logic [1:0] S_SWITCH = 2'b11;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_MODE - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};

  logic [DIV_W-1:0]  pre, pre_nxt;
  logic [1:0]        state_nxt, mode_nxt;
  logic [STEP_W-1:0] step_nxt;
  logic              ret_pause, ret_nxt;
  logic              flush_nxt;
  logic              tick_now;
  logic              mode_diff;

`ifdef SCHED_DWELL_EN
  localparam int DWELL_W = $clog2(DWELL_TICKS + 1);
  localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(DWELL_TICKS);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  logic               dwell, dwell_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
`endif

  // A step lands in the RUN cycle that holds the terminal prescaler count.
  assign tick_now  = (state == S_RUN) && (pre == DIV_LAST);
  assign mode_diff = (man_mode != eng_mode);

  always_comb begin
    state_nxt = state;
    mode_nxt  = eng_mode;
    step_nxt  = step_cnt;
    pre_nxt   = pre;
    ret_nxt   = ret_pause;
    flush_nxt = 1'b0;
`ifdef SCHED_DWELL_EN
    dwell_nxt     = dwell;
    dwell_cnt_nxt = dwell_cnt;
`endif
    case (state)
      S_IDLE: begin
        pre_nxt = '0;
        if (run_req) begin
          state_nxt = S_RUN;
          mode_nxt  = auto_en ? 2'b00 : man_mode;
        end
      end
      S_RUN: begin
        pre_nxt = (pre == DIV_LAST) ? '0 : pre + 1'b1;
        if (tick_now && (step_cnt != STEP_MAX))
          step_nxt = step_cnt + 1'b1;
        if ((auto_en && tick_now && (step_cnt == STEP_LAST)) ||
            (auto_en && next_req && !run_req) ||
            (!auto_en && mode_diff)) begin
          state_nxt = S_SWITCH;
          ret_nxt   = run_req;
        end else if (run_req) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (run_req) begin
          state_nxt = S_RUN;
        end else if ((auto_en && next_req) || (!auto_en && mode_diff)) begin
          state_nxt = S_SWITCH;
          ret_nxt   = 1'b1;
        end
      end
      default: begin
        ret_nxt = ret_pause ^ run_req;
`ifdef SCHED_DWELL_EN
        if (!dwell) begin
          mode_nxt  = auto_en ? eng_mode + 2'd1 : man_mode;
          step_nxt  = '0;
          pre_nxt   = '0;
          flush_nxt = 1'b1;
          if (auto_en) begin
            dwell_nxt     = 1'b1;
            dwell_cnt_nxt = DWELL_INIT;
          end else begin
            state_nxt = ret_nxt ? S_PAUSE : S_RUN;
          end
        end else if (next_req) begin
          mode_nxt      = eng_mode + 2'd1;
          pre_nxt       = '0;
          flush_nxt     = 1'b1;
          dwell_cnt_nxt = DWELL_INIT;
        end else if (pre == DIV_LAST) begin
          pre_nxt = '0;
          if (dwell_cnt == DWELL_ONE) begin
            dwell_nxt = 1'b0;
            state_nxt = ret_nxt ? S_PAUSE : S_RUN;
          end else begin
            dwell_cnt_nxt = dwell_cnt - 1'b1;
          end
        end else begin
          pre_nxt = pre + 1'b1;
        end
`else
        mode_nxt  = auto_en ? eng_mode + 2'd1 : man_mode;
        step_nxt  = '0;
        pre_nxt   = '0;
        flush_nxt = 1'b1;
        state_nxt = ret_nxt ? S_PAUSE : S_RUN;
`endif
      end
    endcase
  end

  // Outputs are registered from next-state values so resume after PAUSE keeps tick phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      eng_mode  <= 2'b00;
      step_cnt  <= '0;
      pre       <= '0;
      ret_pause <= 1'b0;
      eng_tick  <= 1'b0;
      eng_ss    <= 1'b1;
    end else begin
      state     <= state_nxt;
      eng_mode  <= mode_nxt;
      step_cnt  <= step_nxt;
      pre       <= pre_nxt;
      ret_pause <= ret_nxt;
      eng_tick  <= flush_nxt || ((state_nxt == S_RUN) && (pre_nxt == DIV_LAST));
      eng_ss    <= !(flush_nxt || (state_nxt == S_RUN));
    end
  end

`ifdef SCHED_DWELL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell     <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      dwell     <= dwell_nxt;
      dwell_cnt <= dwell_cnt_nxt;
    end
  end
`endif

endmodule
